// File: rtl/vdic_mult_pkg.sv
// Shared types and helpers for the parity-protected sequential multiplier.
// Holds the FSM state encoding, the default operand width and the parity function.
package vdic_mult_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CALC     = 2'd1,
    DONE     = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  localparam int DATA_W_DEFAULT = 16;

  // Zero-extension does not change XOR parity, so one 64-bit helper covers every legal width.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/vdic_mult_iter_core.sv
// Iterative shift-add core: multiplies two unsigned magnitudes in DATA_W steps
// and applies the sign of the product on the way out.
module vdic_mult_iter_core
  import vdic_mult_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     mag_a,
  input  logic [DATA_W-1:0]     mag_b,
  input  logic                  neg,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] ITER_ONE  = CNT_W'(1);
  localparam logic [2*DATA_W-1:0] ACC_ONE = {{(2*DATA_W-1){1'b0}}, 1'b1};

  logic [2*DATA_W-1:0] acc_r;
  logic [CNT_W-1:0]    iter_r;
  logic                busy_r;
  logic [2*DATA_W-1:0] addend_s;

  // partial product selected by the current multiplier bit
  always_comb begin
    addend_s = {(2*DATA_W){1'b0}};
    if (mag_b[iter_r]) begin
      addend_s = {{DATA_W{1'b0}}, mag_a} << iter_r;
    end else begin
      addend_s = {(2*DATA_W){1'b0}};
    end
  end

  // accumulator and iteration counter; operands are held stable by the caller while busy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r  <= {(2*DATA_W){1'b0}};
      iter_r <= {CNT_W{1'b0}};
      busy_r <= 1'b0;
    end else if (start) begin
      acc_r  <= {(2*DATA_W){1'b0}};
      iter_r <= {CNT_W{1'b0}};
      busy_r <= 1'b1;
    end else if (busy_r) begin
      acc_r  <= acc_r + addend_s;
      iter_r <= iter_r + ITER_ONE;
      if (iter_r == LAST_ITER) begin
        busy_r <= 1'b0;
      end
    end
  end

  assign busy    = busy_r;
  assign done    = busy_r && (iter_r == LAST_ITER);
  assign product = neg ? (~acc_r + ACC_ONE) : acc_r;

endmodule

// File: rtl/vdic_mult_seq.sv
// Parametrised sequential multiplier with even-parity checked operands,
// req/ack capture handshake and a one-cycle result_rdy pulse.
module vdic_mult_seq
  import vdic_mult_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     arg_a,
  input  logic                  arg_a_parity,
  input  logic [DATA_W-1:0]     arg_b,
  input  logic                  arg_b_parity,
  input  logic                  mode_signed,
  input  logic                  req,
  output logic                  ack,
  output logic [2*DATA_W-1:0]   result,
  output logic                  result_parity,
  output logic                  result_rdy,
  output logic                  arg_parity_error
);

  localparam logic [DATA_W-1:0] ONE_W = {{(DATA_W-1){1'b0}}, 1'b1};

  state_t              state_r;
  state_t              state_s;
  logic [DATA_W-1:0]   mag_a_s;
  logic [DATA_W-1:0]   mag_b_s;
  logic                neg_s;
  logic                par_ok_s;
  logic                capture_s;
  logic                start_s;
  logic [DATA_W-1:0]   mag_a_r;
  logic [DATA_W-1:0]   mag_b_r;
  logic                neg_r;
  logic                par_err_r;
  logic                core_busy_s;
  logic                core_done_s;
  logic [2*DATA_W-1:0] core_product_s;

  // magnitudes and product sign derived from the live operands; the most negative value maps to 2^(DATA_W-1)
  always_comb begin
    if (mode_signed && arg_a[DATA_W-1]) begin
      mag_a_s = ~arg_a + ONE_W;
    end else begin
      mag_a_s = arg_a;
    end
    if (mode_signed && arg_b[DATA_W-1]) begin
      mag_b_s = ~arg_b + ONE_W;
    end else begin
      mag_b_s = arg_b;
    end
    neg_s    = mode_signed && (arg_a[DATA_W-1] ^ arg_b[DATA_W-1]);
    par_ok_s = (arg_a_parity == even_parity(64'(arg_a))) &&
               (arg_b_parity == even_parity(64'(arg_b)));
  end

  assign capture_s = (state_r == IDLE) && req;
  assign start_s   = capture_s && par_ok_s;

  // operand capture registers, loaded only on an IDLE request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mag_a_r   <= {DATA_W{1'b0}};
      mag_b_r   <= {DATA_W{1'b0}};
      neg_r     <= 1'b0;
      par_err_r <= 1'b0;
    end else if (capture_s) begin
      mag_a_r   <= mag_a_s;
      mag_b_r   <= mag_b_s;
      neg_r     <= neg_s;
      par_err_r <= !par_ok_s;
    end
  end

  vdic_mult_iter_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_s),
    .mag_a   (mag_a_r),
    .mag_b   (mag_b_r),
    .neg     (neg_r),
    .busy    (core_busy_s),
    .done    (core_done_s),
    .product (core_product_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; an idle core in CALC can only follow a corrupted state, so recover to IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req) begin
          state_s = par_ok_s ? CALC : DONE;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (core_done_s) begin
          state_s = DONE;
        end else if (!core_busy_s) begin
          state_s = IDLE;
        end else begin
          state_s = CALC;
        end
      end
      DONE: begin
        state_s = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!req) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_LOW;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // registered outputs; result fields only move when leaving DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack              <= 1'b0;
      result           <= {(2*DATA_W){1'b0}};
      result_parity    <= 1'b0;
      result_rdy       <= 1'b0;
      arg_parity_error <= 1'b0;
    end else begin
      ack        <= capture_s;
      result_rdy <= (state_r == DONE);
      if (state_r == DONE) begin
        if (par_err_r) begin
          result           <= {(2*DATA_W){1'b0}};
          result_parity    <= 1'b0;
          arg_parity_error <= 1'b1;
        end else begin
          result           <= core_product_s;
          result_parity    <= even_parity(64'(core_product_s));
          arg_parity_error <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vdic_mult_seq.sv
// Block-level bench for vdic_mult_seq: directed and random operations on a 16-bit
// and an 8-bit instance, compared against plain integer multiplication.
module tb_vdic_mult_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a16, b16;
  logic        pa16, pb16, ms16, req16;
  logic        ack16, rp16, rdy16, err16;
  logic [31:0] res16;
  logic [7:0]  a8, b8;
  logic        pa8, pb8, ms8, req8;
  logic        ack8, rp8, rdy8, err8;
  logic [15:0] res8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vdic_mult_seq #(.DATA_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .arg_a(a16), .arg_a_parity(pa16), .arg_b(b16),
    .arg_b_parity(pb16), .mode_signed(ms16), .req(req16), .ack(ack16),
    .result(res16), .result_parity(rp16), .result_rdy(rdy16), .arg_parity_error(err16));

  vdic_mult_seq #(.DATA_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .arg_a(a8), .arg_a_parity(pa8), .arg_b(b8),
    .arg_b_parity(pb8), .mode_signed(ms8), .req(req8), .ack(ack8),
    .result(res8), .result_parity(rp8), .result_rdy(rdy8), .arg_parity_error(err8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact product of the operands interpreted per mode, truncated to 2*w bits.
  function automatic logic [31:0] ref_product(input bit is8, input logic [15:0] a,
                                              input logic [15:0] b, input logic ms);
    longint va, vb;
    logic [63:0] p;
    if (is8) begin
      va = ms ? longint'($signed(a[7:0])) : longint'(a[7:0]);
      vb = ms ? longint'($signed(b[7:0])) : longint'(b[7:0]);
    end else begin
      va = ms ? longint'($signed(a)) : longint'(a);
      vb = ms ? longint'($signed(b)) : longint'(b);
    end
    p = 64'(va * vb);
    return is8 ? {16'h0000, p[15:0]} : p[31:0];
  endfunction

  // One complete request: drive, count acks, measure ack->rdy latency, check the result and its hold.
  task automatic run_op(input bit is8, input logic [15:0] a, input logic [15:0] b,
                        input logic ms, input logic bad_pa, input logic bad_pb, input string name);
    logic [31:0] exp_r, got_r;
    logic        exp_err, got_p, got_e, s_ack, s_rdy;
    int cyc, ack_at, rdy_at, n_ack, w;
    w       = is8 ? 8 : 16;
    exp_err = bad_pa | bad_pb;
    exp_r   = exp_err ? 32'h0 : ref_product(is8, a, b, ms);
    if (is8) begin
      a8 = a[7:0]; b8 = b[7:0]; pa8 = (^a[7:0]) ^ bad_pa; pb8 = (^b[7:0]) ^ bad_pb;
      ms8 = ms; req8 = 1'b1;
    end else begin
      a16 = a; b16 = b; pa16 = (^a) ^ bad_pa; pb16 = (^b) ^ bad_pb;
      ms16 = ms; req16 = 1'b1;
    end
    cyc = 0; ack_at = -1; rdy_at = -1; n_ack = 0;
    got_r = 32'h0; got_p = 1'b0; got_e = 1'b0;
    while (rdy_at < 0 && cyc < 60) begin
      tick();
      cyc++;
      s_ack = is8 ? ack8 : ack16;
      s_rdy = is8 ? rdy8 : rdy16;
      if (s_ack) begin
        n_ack++;
        ack_at = cyc;
      end
      if (s_rdy) begin
        rdy_at = cyc;
        got_r  = is8 ? {16'h0000, res8} : res16;
        got_p  = is8 ? rp8 : rp16;
        got_e  = is8 ? err8 : err16;
      end
    end
    req8 = 1'b0; req16 = 1'b0;
    checks++;
    if (rdy_at < 0) begin
      errors++;
      $display("FAIL %s timeout: no result_rdy within %0d cycles", name, cyc);
    end
    checks++;
    if (n_ack !== 1) begin
      errors++;
      $display("FAIL %s ack_count: got %0d expected 1", name, n_ack);
    end
    checks++;
    if (rdy_at - ack_at !== (exp_err ? 1 : w + 1)) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, rdy_at - ack_at, exp_err ? 1 : w + 1);
    end
    checks++;
    if (got_r !== exp_r) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", name, got_r, exp_r);
    end
    checks++;
    if (got_p !== ^exp_r) begin
      errors++;
      $display("FAIL %s result_parity: got %b expected %b", name, got_p, ^exp_r);
    end
    checks++;
    if (got_e !== exp_err) begin
      errors++;
      $display("FAIL %s arg_parity_error: got %b expected %b", name, got_e, exp_err);
    end
    tick();
    got_r = is8 ? {16'h0000, res8} : res16;
    checks++;
    if (got_r !== exp_r) begin
      errors++;
      $display("FAIL %s result_hold: got %h expected %h", name, got_r, exp_r);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req16 = 1'b0; req8 = 1'b0;
    a16 = 16'h0; b16 = 16'h0; pa16 = 1'b0; pb16 = 1'b0; ms16 = 1'b0;
    a8 = 8'h0; b8 = 8'h0; pa8 = 1'b0; pb8 = 1'b0; ms8 = 1'b0;
    repeat (3) tick();
    checks++;
    if ({ack16, res16, rp16, rdy16, err16} !== 36'h0) begin
      errors++;
      $display("FAIL reset16: got %h expected 0", {ack16, res16, rp16, rdy16, err16});
    end
    checks++;
    if ({ack8, res8, rp8, rdy8, err8} !== 20'h0) begin
      errors++;
      $display("FAIL reset8: got %h expected 0", {ack8, res8, rp8, rdy8, err8});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    run_op(1'b0, 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0, "s_min_min");
    run_op(1'b0, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b0, "s_max_max");
    run_op(1'b0, 16'hFFFF, 16'h0002, 1'b1, 1'b0, 1'b0, "s_m1_x2");
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, "u_ffff_sq");
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, "s_ffff_sq");
    run_op(1'b0, 16'h0000, 16'h8001, 1'b1, 1'b0, 1'b0, "s_zero");
  endtask

  task automatic test_parity_error();
    run_op(1'b0, 16'h0001, 16'h1234, 1'b0, 1'b1, 1'b0, "perr_a");
    run_op(1'b0, 16'h00F0, 16'h0003, 1'b1, 1'b0, 1'b1, "perr_b");
    run_op(1'b0, 16'h1234, 16'h0003, 1'b0, 1'b0, 1'b0, "after_perr");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_op(1'b0, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0), 1'b0, "rand16");
    end
  endtask

  task automatic test_req_held();
    int n_ack, n_rdy, cyc;
    logic [31:0] exp_r;
    a16 = 16'h0123; b16 = 16'h0456; pa16 = ^a16; pb16 = ^b16; ms16 = 1'b0; req16 = 1'b1;
    exp_r = ref_product(1'b0, 16'h0123, 16'h0456, 1'b0);
    n_ack = 0; n_rdy = 0; cyc = 0;
    while (n_rdy == 0 && cyc < 60) begin
      tick();
      cyc++;
      n_ack += int'(ack16);
      n_rdy += int'(rdy16);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_ack += int'(ack16);
      n_rdy += int'(rdy16);
    end
    checks++;
    if (n_ack !== 1 || n_rdy !== 1) begin
      errors++;
      $display("FAIL held_counts: got ack=%0d rdy=%0d expected 1 and 1", n_ack, n_rdy);
    end
    checks++;
    if (res16 !== exp_r) begin
      errors++;
      $display("FAIL held_result: got %h expected %h", res16, exp_r);
    end
    req16 = 1'b0;
    tick();
    checks++;
    if (ack16 !== 1'b0) begin
      errors++;
      $display("FAIL held_no_ack_low: got %b expected 0", ack16);
    end
    a16 = 16'hFFFE; b16 = 16'h0003; pa16 = ^a16; pb16 = ^b16; ms16 = 1'b1; req16 = 1'b1;
    tick();
    checks++;
    if (ack16 !== 1'b1) begin
      errors++;
      $display("FAIL held_reack: got %b expected 1", ack16);
    end
    req16 = 1'b0;
    repeat (20) tick();
    checks++;
    if (res16 !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL held_second_result: got %h expected fffffffa", res16);
    end
  endtask

  task automatic test_reset_mid_calc();
    int n_rdy, cyc;
    a16 = 16'h1357; b16 = 16'h2468; pa16 = ^a16; pb16 = ^b16; ms16 = 1'b0; req16 = 1'b1;
    cyc = 0;
    while (ack16 !== 1'b1 && cyc < 10) begin
      tick();
      cyc++;
    end
    repeat (8) tick();
    rst_n = 1'b0; req16 = 1'b0;
    tick();
    checks++;
    if ({ack16, res16, rp16, rdy16, err16} !== 36'h0) begin
      errors++;
      $display("FAIL midcalc_reset: got %h expected 0", {ack16, res16, rp16, rdy16, err16});
    end
    rst_n = 1'b1;
    n_rdy = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      n_rdy += int'(rdy16);
    end
    checks++;
    if (n_rdy !== 0) begin
      errors++;
      $display("FAIL midcalc_no_rdy: got %0d pulses expected 0", n_rdy);
    end
    run_op(1'b0, 16'h1357, 16'h2468, 1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_dw8();
    run_op(1'b1, 16'h0080, 16'h0080, 1'b1, 1'b0, 1'b0, "w8_s_min_min");
    run_op(1'b1, 16'h00FF, 16'h00FF, 1'b0, 1'b0, 1'b0, "w8_u_ff_sq");
    run_op(1'b1, 16'h00FF, 16'h00FF, 1'b1, 1'b0, 1'b0, "w8_s_ff_sq");
    run_op(1'b1, 16'h0001, 16'h0005, 1'b0, 1'b1, 1'b0, "w8_perr");
    for (int i = 0; i < 12; i++) begin
      run_op(1'b1, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'b0, 1'b0, "rand8");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_parity_error();
    test_random();
    test_req_held();
    test_reset_mid_calc();
    test_dw8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
